// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared HSIZE encodings, width helpers and request-entry sizing for the AHB-to-APB bridge.
package ahb2apb_pkg;
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int ENTRY_W = DEF_AW + DEF_DW + 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // address + data + 3-bit HSIZE + HWRITE
    function automatic int entry_w(input int aw, input int dw);
        return aw + dw + 4;
    endfunction
endpackage

// File: rtl/ahb_req_fifo_ptr.sv
// ahb_req_fifo_ptr: pointer, level and status-flag control for the request FIFO.
module ahb_req_fifo_ptr
    import ahb2apb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AFULL_LVL = DEPTH - 2,
    parameter int AEMPTY_LVL = 1,
    localparam int LW = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_write,
    input  logic          i_read,
    output logic          o_we,
    output logic          o_re,
    output logic [LW-2:0] o_widx,
    output logic [LW-2:0] o_ridx,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_afull,
    output logic          o_aempty
);
    logic [LW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, level_q, level_d;

    always_comb begin
        o_full   = level_q == LW'(DEPTH);
        o_empty  = level_q == '0;
        o_afull  = level_q >= LW'(AFULL_LVL);
        o_aempty = level_q <= LW'(AEMPTY_LVL);
        o_re     = i_read & ~o_empty & ~i_flush;
        // a pop frees the slot the push needs, so full only blocks a lone push
        o_we     = i_write & (~o_full | i_read) & ~i_flush;
        w_ptr_d  = i_flush ? '0 : w_ptr_q + LW'(o_we);
        r_ptr_d  = i_flush ? '0 : r_ptr_q + LW'(o_re);
        level_d  = i_flush ? '0 : level_q + LW'(o_we) - LW'(o_re);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
        end
    end

    assign o_widx  = w_ptr_q[LW-2:0];
    assign o_ridx  = r_ptr_q[LW-2:0];
    assign o_level = level_q;
endmodule

// File: rtl/ahb_req_fifo.sv
// ahb_req_fifo: show-ahead AHB request buffer with flush, level, almost flags and sticky error flags.
module ahb_req_fifo
    import ahb2apb_pkg::*;
#(
    parameter int AHB_AW = 32,
    parameter int AHB_DW = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int AFULL_LVL = FIFO_DEPTH - 2,
    parameter int AEMPTY_LVL = 1,
    localparam int LW = clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_write,
    input  logic [AHB_AW-1:0] i_haddr,
    input  logic [AHB_DW-1:0] i_hwdata,
    input  logic [2:0]        i_hsize,
    input  logic              i_hwrite,
    input  logic              i_read,
    input  logic              i_clr_err,
    output logic [AHB_AW-1:0] o_haddr,
    output logic [AHB_DW-1:0] o_hwdata,
    output logic [2:0]        o_hsize,
    output logic              o_hwrite,
    output logic              o_fifo_full,
    output logic              o_fifo_empty,
    output logic              o_fifo_afull,
    output logic              o_fifo_aempty,
    output logic [LW-1:0]     o_level,
    output logic              o_overflow,
    output logic              o_underflow
);
    localparam int EW = entry_w(AHB_AW, AHB_DW);

    logic          we, re, ovf_q, ovf_d, unf_q, unf_d;
    logic [LW-2:0] widx, ridx;
    logic [EW-1:0] mem [FIFO_DEPTH];

    ahb_req_fifo_ptr #(
        .DEPTH(FIFO_DEPTH),
        .AFULL_LVL(AFULL_LVL),
        .AEMPTY_LVL(AEMPTY_LVL)
    ) u_ptr (
        .clk(clk),
        .rst(rst),
        .i_flush(i_flush),
        .i_write(i_write),
        .i_read(i_read),
        .o_we(we),
        .o_re(re),
        .o_widx(widx),
        .o_ridx(ridx),
        .o_level(o_level),
        .o_full(o_fifo_full),
        .o_empty(o_fifo_empty),
        .o_afull(o_fifo_afull),
        .o_aempty(o_fifo_aempty)
    );

    // a new error in the same cycle wins over the clear request
    always_comb begin
        ovf_d = (~i_flush & i_write & o_fifo_full & ~i_read) | (ovf_q & ~i_clr_err);
        unf_d = (~i_flush & i_read & o_fifo_empty) | (unf_q & ~i_clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= {i_hwrite, i_hsize, i_hwdata, i_haddr};
    end

    assign {o_hwrite, o_hsize, o_hwdata, o_haddr} = mem[ridx];
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
endmodule

// File: tb/tb_ahb_req_fifo.sv
// tb_ahb_req_fifo: randomized and directed bench for depth-8 and depth-4 request FIFOs against a queue-level model.
module tb_ahb_req_fifo;
    typedef logic [67:0] ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fl, wr, rd, clr, hw;
    logic [31:0] addr, data;
    logic [2:0]  size;

    logic [31:0] h8_addr, h8_data, h4_addr, h4_data;
    logic [2:0]  h8_size, h4_size;
    logic        h8_hw, h4_hw, full8, empty8, afull8, aempty8, ov8, un8;
    logic        full4, empty4, afull4, aempty4, ov4, un4;
    logic [3:0]  lv8;
    logic [2:0]  lv4;

    ahb_req_fifo u8 (
        .clk(clk), .rst(rst), .i_flush(fl), .i_write(wr), .i_haddr(addr), .i_hwdata(data),
        .i_hsize(size), .i_hwrite(hw), .i_read(rd), .i_clr_err(clr),
        .o_haddr(h8_addr), .o_hwdata(h8_data), .o_hsize(h8_size), .o_hwrite(h8_hw),
        .o_fifo_full(full8), .o_fifo_empty(empty8), .o_fifo_afull(afull8), .o_fifo_aempty(aempty8),
        .o_level(lv8), .o_overflow(ov8), .o_underflow(un8)
    );

    ahb_req_fifo #(.FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .i_flush(fl), .i_write(wr), .i_haddr(addr), .i_hwdata(data),
        .i_hsize(size), .i_hwrite(hw), .i_read(rd), .i_clr_err(clr),
        .o_haddr(h4_addr), .o_hwdata(h4_data), .o_hsize(h4_size), .o_hwrite(h4_hw),
        .o_fifo_full(full4), .o_fifo_empty(empty4), .o_fifo_afull(afull4), .o_fifo_aempty(aempty4),
        .o_level(lv4), .o_overflow(ov4), .o_underflow(un4)
    );

    int   checks = 0, errors = 0;
    ent_t sb [2][1024];
    int   wp [2] = '{0, 0};
    int   rp [2] = '{0, 0};
    bit   mov [2] = '{0, 0};
    bit   mun [2] = '{0, 0};
    int   dep [2] = '{8, 4};

    // Drive one cycle, advance the model on the edge, then sample 1ns later.
    task automatic cyc(input bit r, f, w, d, c, input logic [31:0] a, dt, input logic [2:0] s, input bit h);
        int lvl;
        bit so, su;
        rst = r; fl = f; wr = w; rd = d; clr = c; addr = a; data = dt; size = s; hw = h;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            lvl = wp[k] - rp[k];
            if (r) begin
                wp[k] = 0; rp[k] = 0; mov[k] = 0; mun[k] = 0;
            end else begin
                so = !f && w && lvl == dep[k] && !d;
                su = !f && d && lvl == 0;
                mov[k] = so || (mov[k] && !c);
                mun[k] = su || (mun[k] && !c);
                if (f) rp[k] = wp[k];
                else begin
                    if (w && (lvl < dep[k] || d)) begin
                        sb[k][wp[k] % 1024] = {h, s, dt, a};
                        wp[k]++;
                    end
                    if (d && lvl > 0) rp[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic push(input logic [31:0] a, dt, input bit h);
        cyc(0, 0, 1, 0, 0, a, dt, 3'b010, h);
    endtask

    task automatic idle(input bit c);
        cyc(0, 0, 0, 0, c, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        cyc(1, 0, 1, 1, 0, 32'hDEAD, 1, 0, 0);
        checks++; if (lv8 !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", lv8); end
        checks++; if ({empty8, full8, aempty8, afull8} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b want 1010", {empty8, full8, aempty8, afull8}); end
        checks++; if ({ov8, un8} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {ov8, un8}); end
        checks++; if (lv4 !== 3'd0 || empty4 !== 1'b1) begin errors++; $display("FAIL reset_d4 level %0d empty %b want 0 1", lv4, empty4); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(4 * i), 32'(i), i[0]);
            checks++; if (lv8 !== 4'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got %0d want %0d", i, lv8, i + 1); end
            checks++; if (afull8 !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull8, i + 1 >= 6); end
            checks++; if (full8 !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, full8, i == 7); end
            checks++; if ({h8_hw, h8_size, h8_data, h8_addr} !== {1'b0, 3'b010, 32'd0, 32'h100}) begin errors++; $display("FAIL fill_head[%0d] got %h want 100", i, h8_addr); end
        end
        push(32'h120, 32'd8, 1'b0);
        checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", ov8); end
        checks++; if (lv8 !== 4'd8) begin errors++; $display("FAIL overflow_level got %0d want 8", lv8); end
    endtask

    task automatic test_full_rw;
        logic [31:0] ea;
        idle(1);
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", ov8); end
        cyc(0, 0, 1, 1, 0, 32'h200, 32'hA5, 3'b010, 1'b1);
        checks++; if (lv8 !== 4'd8 || ov8 !== 1'b0) begin errors++; $display("FAIL full_rw level %0d ovf %b want 8 0", lv8, ov8); end
        checks++; if (h8_addr !== 32'h104 || h8_data !== 32'd1) begin errors++; $display("FAIL full_rw_head got %h/%0d want 104/1", h8_addr, h8_data); end
        for (int i = 0; i < 8; i++) begin
            ea = (i < 7) ? 32'h104 + 32'(4 * i) : 32'h200;
            checks++; if (h8_addr !== ea) begin errors++; $display("FAIL drain[%0d] got %h want %h", i, h8_addr, ea); end
            cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        end
        checks++; if (empty8 !== 1'b1 || un8 !== 1'b0) begin errors++; $display("FAIL drain_end empty %b unf %b want 1 0", empty8, un8); end
    endtask

    task automatic test_underflow;
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (un8 !== 1'b1 || lv8 !== 4'd0) begin errors++; $display("FAIL underflow unf %b level %0d want 1 0", un8, lv8); end
        idle(1);
        checks++; if ({ov8, un8} !== 2'b00) begin errors++; $display("FAIL clr_err got %b want 00", {ov8, un8}); end
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        checks++; if (un8 !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", un8); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(i), 32'(i), 1'b1);
        checks++; if (lv8 !== 4'd5) begin errors++; $display("FAIL pre_flush level %0d want 5", lv8); end
        cyc(0, 1, 1, 0, 0, 32'h3FF, 32'h77, 3'b000, 1'b0);
        checks++; if (lv8 !== 4'd0 || empty8 !== 1'b1) begin errors++; $display("FAIL flush level %0d empty %b want 0 1", lv8, empty8); end
        checks++; if ({ov8, un8} !== 2'b01) begin errors++; $display("FAIL flush_err got %b want 01", {ov8, un8}); end
        checks++; if (lv4 !== 3'd0 || ov4 !== 1'b1) begin errors++; $display("FAIL flush_d4 level %0d ovf %b want 0 1", lv4, ov4); end
        idle(0);
        checks++; if (empty8 !== 1'b1) begin errors++; $display("FAIL flush_nocapture empty %b want 1", empty8); end
    endtask

    task automatic test_random;
        bit w, d;
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int n = 0; n < 80; n++) begin
            w = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            cyc(0, 0, w, d, 0, $urandom, $urandom, 3'($urandom_range(0, 2)), 1'($urandom));
            checks++; if (lv8 !== 4'(wp[0] - rp[0]) || lv8 > 4'd8) begin errors++; $display("FAIL rnd8_level[%0d] got %0d want %0d", n, lv8, wp[0] - rp[0]); end
            checks++; if (lv4 !== 3'(wp[1] - rp[1]) || lv4 > 3'd4) begin errors++; $display("FAIL rnd4_level[%0d] got %0d want %0d", n, lv4, wp[1] - rp[1]); end
            checks++; if ({ov8, un8, ov4, un4} !== {mov[0], mun[0], mov[1], mun[1]}) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", n, {ov8, un8, ov4, un4}, {mov[0], mun[0], mov[1], mun[1]}); end
            checks++; if (full4 !== (wp[1] - rp[1] == 4) || empty4 !== (wp[1] == rp[1])) begin errors++; $display("FAIL rnd4_flags[%0d] got %b%b", n, full4, empty4); end
            if (wp[0] != rp[0]) begin
                checks++; if ({h8_hw, h8_size, h8_data, h8_addr} !== sb[0][rp[0] % 1024]) begin errors++; $display("FAIL rnd8_head[%0d] got %h want %h", n, {h8_hw, h8_size, h8_data, h8_addr}, sb[0][rp[0] % 1024]); end
            end
            if (wp[1] != rp[1]) begin
                checks++; if ({h4_hw, h4_size, h4_data, h4_addr} !== sb[1][rp[1] % 1024]) begin errors++; $display("FAIL rnd4_head[%0d] got %h want %h", n, {h4_hw, h4_size, h4_data, h4_addr}, sb[1][rp[1] % 1024]); end
            end
        end
    endtask

    task automatic test_rst_mid;
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(i), 32'(i), 1'b0);
        checks++; if (lv8 !== 4'd3 || un8 !== 1'b1) begin errors++; $display("FAIL pre_rst level %0d unf %b want 3 1", lv8, un8); end
        cyc(1, 0, 1, 0, 0, 32'h4FF, 0, 0, 0);
        checks++; if (lv8 !== 4'd0 || empty8 !== 1'b1) begin errors++; $display("FAIL rst_mid level %0d empty %b want 0 1", lv8, empty8); end
        checks++; if ({ov8, un8, ov4, un4} !== 4'b0000) begin errors++; $display("FAIL rst_mid_err got %b want 0000", {ov8, un8, ov4, un4}); end
        checks++; if (lv4 !== 3'd0) begin errors++; $display("FAIL rst_mid_d4 level %0d want 0", lv4); end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_full_rw;
        test_underflow;
        test_flush;
        test_random;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
